// File: rtl/seq_scan_ctrl.sv
// Word-to-bit-serial sequencer around an overlapping pattern matcher, one result per word.
// Optional macro SEQ_SCAN_FIRST_IDX_EN adds out_first (index of the first match in the word).
module seq_scan_ctrl #(
    parameter int WORD_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [PAT_MAX-1:0]         cfg_pat,
    input  logic [3:0]                 cfg_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           out_count,
    output logic                       out_hit,
`ifdef SEQ_SCAN_FIRST_IDX_EN
    output logic [$clog2(WORD_W)-1:0]  out_first,
`endif
    output logic                       din,
    output logic                       dout,
    output logic [1:0]                 state
);
    localparam int IDX_W = $clog2(WORD_W);
    localparam int WIN_W = PAT_MAX + 1;
    localparam logic [3:0]         PMAX4    = 4'(PAT_MAX);
    localparam logic [3:0]         RST_LEN  = (PAT_MAX < 3) ? 4'(PAT_MAX) : 4'd3;
    localparam logic [PAT_MAX-1:0] RST_PAT  = PAT_MAX'(7);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [WIN_W-1:0]   WIN_ONES = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        REPORT = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PAT_MAX-1:0]  hist_q, hist_d;
    logic [3:0]          fill_q, fill_d;
    logic [PAT_MAX-1:0]  pat_q, pat_d;
    logic [3:0]          len_q, len_d;
    logic                dout_q, dout_d;
`ifdef SEQ_SCAN_FIRST_IDX_EN
    logic [IDX_W-1:0]    first_q, first_d;
`endif

    logic                bit_cur;
    logic [WIN_W-1:0]    window;
    logic [WIN_W-1:0]    mask;
    logic [4:0]          fill_inc;
    logic                match;

    // The word register shifts left, so its MSB is always the bit under test.
    assign bit_cur  = word_q[WORD_W-1];
    assign window   = {hist_q, bit_cur};
    assign mask     = ~(WIN_ONES << len_q);
    assign fill_inc = {1'b0, fill_q} + 5'd1;
    assign match    = (state_q == SHIFT) && (len_q != 4'd0) &&
                      (fill_inc >= {1'b0, len_q}) &&
                      (((window ^ {1'b0, pat_q}) & mask) == '0);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        dout_d  = match;
`ifdef SEQ_SCAN_FIRST_IDX_EN
        first_d = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pat_d  = cfg_pat;
                    len_d  = (cfg_len > PMAX4) ? PMAX4 : cfg_len;
                    hist_d = '0;
                    fill_d = '0;
                end
                if (in_valid) begin
                    word_d  = in_data;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef SEQ_SCAN_FIRST_IDX_EN
                    first_d = '0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                hist_d = window[PAT_MAX-1:0];
                fill_d = (fill_q == PMAX4) ? fill_q : fill_inc[3:0];
                word_d = word_q << 1;
                idx_d  = idx_q + IDX_ONE;
                if (match) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
`ifdef SEQ_SCAN_FIRST_IDX_EN
                    if (cnt_q == '0) first_d = idx_q;
`endif
                end
                if (idx_q == LAST_IDX) state_d = REPORT;
            end
            REPORT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= RST_PAT;
            len_q   <= RST_LEN;
            dout_q  <= 1'b0;
`ifdef SEQ_SCAN_FIRST_IDX_EN
            first_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
`ifdef SEQ_SCAN_FIRST_IDX_EN
            first_q <= first_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == REPORT);
    assign out_count = cnt_q;
    assign out_hit   = (cnt_q != '0);
    assign din       = (state_q == SHIFT) ? bit_cur : 1'b0;
    assign dout      = dout_q;
    assign state     = state_q;
`ifdef SEQ_SCAN_FIRST_IDX_EN
    assign out_first = first_q;
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomized bench for seq_scan_ctrl against a bit-stream reference model.
// CNT_W=3 so both unsaturated counts and saturation are reachable with 8-bit words.
module tb_seq_scan_ctrl;
    localparam int WORD_W  = 8;
    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [PAT_MAX-1:0] cfg_pat = '0;
    logic [3:0]         cfg_len = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CNT_W-1:0]   out_count;
    logic               out_hit;
`ifdef SEQ_SCAN_FIRST_IDX_EN
    logic [$clog2(WORD_W)-1:0] out_first;
`endif
    logic               din;
    logic               dout;
    logic [1:0]         state;

    seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_hit(out_hit),
`ifdef SEQ_SCAN_FIRST_IDX_EN
        .out_first(out_first),
`endif
        .din(din), .dout(dout), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the serial bit stream seen since the last reset/config.
    bit                 stream[$];
    logic [PAT_MAX-1:0] mpat;
    int                 mlen;

    function automatic void model_cfg(input logic [PAT_MAX-1:0] p, input int l);
        mpat = p;
        mlen = (l > PAT_MAX) ? PAT_MAX : l;
        stream.delete();
    endfunction

    function automatic bit model_push(input bit b);
        stream.push_back(b);
        if (stream.size() > 32) void'(stream.pop_front());
        if (mlen == 0 || stream.size() < mlen) return 1'b0;
        for (int i = 0; i < mlen; i++)
            if (stream[stream.size()-1-i] != mpat[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_reset_values(input string tag);
        check_val({tag, "_state"},     state,     0);
        check_val({tag, "_in_ready"},  in_ready,  1);
        check_val({tag, "_out_valid"}, out_valid, 0);
        check_val({tag, "_dout"},      dout,      0);
        check_val({tag, "_din"},       din,       0);
        check_val({tag, "_count"},     out_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        model_cfg(PAT_MAX'(7), 3);
    endtask

    // abort_at >= 0 asserts reset after that many SHIFT bits have been processed.
    task automatic send_word(input logic [WORD_W-1:0] w, input bit cfg_now,
                             input logic [PAT_MAX-1:0] p, input int l,
                             input int hold, input bit mid_cfg, input int abort_at);
        bit exp_m[WORD_W];
        int cnt, first, t;
        cnt = 0; first = 0; t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check_val("in_ready_timeout", in_ready, 1);
        if (cfg_now) begin
            cfg_we = 1'b1; cfg_pat = p; cfg_len = 4'(l);
            model_cfg(p, l);
        end
        in_valid = 1'b1; in_data = w;
        for (int k = 0; k < WORD_W; k++) begin
            exp_m[k] = model_push(w[WORD_W-1-k]);
            if (exp_m[k]) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
        if (cnt > CMAX) cnt = CMAX;
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        check_val("accept_state", state, 1);
        check_val("shift_in_ready", in_ready, 0);
        for (int k = 0; k < WORD_W; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1 check_reset_values("abort");
                @(negedge clk);
                rst = 1'b0;
                model_cfg(PAT_MAX'(7), 3);
                return;
            end
            check_val("din", din, w[WORD_W-1-k]);
            if (mid_cfg && k == 3) begin
                cfg_we = 1'b1; cfg_pat = '0; cfg_len = 4'd1;
            end
            @(negedge clk);
            cfg_we = 1'b0;
            check_val("dout", dout, exp_m[k]);
        end
        check_val("report_state", state, 2);
        check_val("out_valid", out_valid, 1);
        check_val("out_count", out_count, cnt);
        check_val("out_hit", out_hit, (cnt != 0));
        check_val("report_in_ready", in_ready, 0);
`ifdef SEQ_SCAN_FIRST_IDX_EN
        check_val("out_first", out_first, first);
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_data = WORD_W'($urandom);
            @(negedge clk);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_count", out_count, cnt);
            check_val("hold_in_ready", in_ready, 0);
            check_val("hold_state", state, 2);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("ret_state", state, 0);
        check_val("ret_out_valid", out_valid, 0);
        check_val("ret_in_ready", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        // Default 111/len3
        send_word(8'hFF, 0, '0, 0, 0, 0, -1);
        send_word(8'h80, 0, '0, 0, 0, 0, -1);
        // Config and accept in the same IDLE cycle
        send_word(8'hAA, 1, 8'b101, 3, 0, 0, -1);
        send_word(8'h00, 0, '0, 0, 0, 0, -1);
        send_word(8'h5A, 0, '0, 0, 5, 0, -1);
        // Config strobe during SHIFT is ignored
        do_reset();
        send_word(8'hFF, 0, '0, 0, 0, 1, -1);
        // Reset in the middle of a word clears history
        send_word(8'h12, 0, '0, 0, 0, 0, 3);
        send_word(8'h07, 0, '0, 0, 0, 0, -1);
        // Saturation, disabled detection, length clamp
        send_word(8'hFF, 1, 8'h01, 1, 0, 0, -1);
        send_word(8'hFF, 1, 8'h00, 0, 0, 0, -1);
        send_word(8'hFF, 1, 8'hFF, 15, 0, 0, -1);
        for (int i = 0; i < 60; i++) begin
            send_word(WORD_W'($urandom), ($urandom_range(0, 3) == 0),
                      PAT_MAX'($urandom), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WORD_W-1)) : -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
